// File: rtl/lsf_engine_scheduler.sv
// Spreads HEG ROIs and their MDT hits over N_ENG Legendre segment-finder engines,
// then merges the engine results round-robin onto a single SF->PTCALC stream.
module lsf_engine_scheduler #(
    parameter int N_ENG   = 2,
    parameter int ROI_W   = 32,
    parameter int HIT_W   = 32,
    parameter int OUT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    resetbar,
    input  logic [ROI_W-1:0]        roi,
    input  logic                    roi_we,
    input  logic [HIT_W-1:0]        mdt_hit,
    input  logic                    mdt_hit_we,
    input  logic                    i_eof,
    output logic [ROI_W-1:0]        eng_roi,
    output logic [N_ENG-1:0]        eng_roi_we,
    output logic [HIT_W-1:0]        eng_hit,
    output logic [N_ENG-1:0]        eng_hit_we,
    output logic [N_ENG-1:0]        eng_eof,
    input  logic [N_ENG*OUT_W-1:0]  eng_out,
    input  logic [N_ENG-1:0]        eng_out_vld,
    output logic [OUT_W-1:0]        lsf_output,
    output logic                    lsf_output_vld,
    output logic [N_ENG-1:0]        eng_busy,
    output logic [15:0]             roi_drop_cnt,
    output logic [15:0]             err_cnt
);

    localparam int IDX_W = $clog2(N_ENG);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]       state, nxt_state;
    logic [IDX_W-1:0] sel, nxt_sel;
    logic [IDX_W-1:0] rr_ptr, nxt_rr;
    logic [IDX_W-1:0] arb_ptr;
    logic [TMR_W-1:0] tmr [N_ENG];
    logic [N_ENG-1:0] hold_vld;
    logic [OUT_W-1:0] hold_data [N_ENG];

    logic [N_ENG-1:0] roi_we_n, hit_we_n, eof_n;
    logic             fwd_hit, load_roi, proto_err, drop_inc;
    logic             free_found, grant_found;
    logic [IDX_W-1:0] free_idx, grant_idx;
    logic [N_ENG-1:0] gnt, timeout, overflow;
    logic [3:0]       err_inc;
    logic [16:0]      err_sum;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(N_ENG - 1)) ? '0 : x + 1'b1;
    endfunction

    // Returns {found, index} of the first set request at or after start, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_ENG-1:0] req,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = next_idx(idx);
        end
        return {found, pick};
    endfunction

    assign {free_found, free_idx}   = rr_pick(~eng_busy, rr_ptr);
    assign {grant_found, grant_idx} = rr_pick(hold_vld, arb_ptr);

    // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        nxt_state = state;
        nxt_sel   = sel;
        nxt_rr    = rr_ptr;
        roi_we_n  = '0;
        hit_we_n  = '0;
        eof_n     = '0;
        fwd_hit   = 1'b0;
        load_roi  = 1'b0;
        proto_err = 1'b0;
        drop_inc  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!roi_we && (mdt_hit_we || i_eof))
                    proto_err = 1'b1;
            end
            ST_ROUTE: begin
                if (roi_we) begin
                    // A new ROI without a closing eof implicitly terminates the open one.
                    eof_n[sel] = 1'b1;
                    proto_err  = 1'b1;
                end else begin
                    if (mdt_hit_we) begin
                        hit_we_n[sel] = 1'b1;
                        fwd_hit       = 1'b1;
                    end
                    if (i_eof) begin
                        eof_n[sel] = 1'b1;
                        nxt_state  = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (roi_we)
                    proto_err = 1'b1;
                else if (i_eof)
                    nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Same-cycle hit and eof belong to the incoming ROI.
        if (roi_we) begin
            if (free_found) begin
                roi_we_n[free_idx] = 1'b1;
                load_roi           = 1'b1;
                nxt_sel            = free_idx;
                nxt_rr             = next_idx(free_idx);
                if (mdt_hit_we) begin
                    hit_we_n[free_idx] = 1'b1;
                    fwd_hit            = 1'b1;
                end
                if (i_eof) begin
                    eof_n[free_idx] = 1'b1;
                    nxt_state       = ST_IDLE;
                end else begin
                    nxt_state = ST_ROUTE;
                end
            end else begin
                drop_inc  = 1'b1;
                nxt_state = i_eof ? ST_IDLE : ST_DROP;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (grant_found)
            gnt[grant_idx] = 1'b1;
        err_inc = {3'b000, proto_err};
        for (int k = 0; k < N_ENG; k++) begin
            timeout[k]  = eng_busy[k] && !eng_out_vld[k] && (tmr[k] == TMR_W'(TIMEOUT - 1));
            overflow[k] = eng_out_vld[k] && hold_vld[k] && !gnt[k];
            err_inc     = err_inc + {3'b000, timeout[k]} + {3'b000, overflow[k]};
        end
        err_sum = {1'b0, err_cnt} + {13'd0, err_inc};
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!resetbar) begin
            state          <= ST_IDLE;
            sel            <= '0;
            rr_ptr         <= '0;
            arb_ptr        <= '0;
            eng_roi        <= '0;
            eng_roi_we     <= '0;
            eng_hit        <= '0;
            eng_hit_we     <= '0;
            eng_eof        <= '0;
            eng_busy       <= '0;
            hold_vld       <= '0;
            lsf_output     <= '0;
            lsf_output_vld <= 1'b0;
            roi_drop_cnt   <= '0;
            err_cnt        <= '0;
            for (int k = 0; k < N_ENG; k++)
                tmr[k] <= '0;
        end else begin
            state      <= nxt_state;
            sel        <= nxt_sel;
            rr_ptr     <= nxt_rr;
            eng_roi_we <= roi_we_n;
            eng_hit_we <= hit_we_n;
            eng_eof    <= eof_n;
            if (load_roi)
                eng_roi <= roi;
            if (fwd_hit)
                eng_hit <= mdt_hit;

            for (int k = 0; k < N_ENG; k++) begin
                if (roi_we_n[k]) begin
                    eng_busy[k] <= 1'b1;
                    tmr[k]      <= '0;
                end else if (eng_busy[k]) begin
                    if (eng_out_vld[k] || timeout[k])
                        eng_busy[k] <= 1'b0;
                    else
                        tmr[k] <= tmr[k] + 1'b1;
                end

                if (eng_out_vld[k] && !overflow[k])
                    hold_vld[k] <= 1'b1;
                else if (gnt[k])
                    hold_vld[k] <= 1'b0;
            end

            lsf_output_vld <= grant_found;
            if (grant_found) begin
                lsf_output <= hold_data[grant_idx];
                arb_ptr    <= next_idx(grant_idx);
            end

            if (drop_inc && roi_drop_cnt != 16'hFFFF)
                roi_drop_cnt <= roi_drop_cnt + 16'd1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // NOTE: hold payloads are not reset; hold_vld alone decides whether they are ever read.
    always_ff @(posedge clock) begin
        for (int k = 0; k < N_ENG; k++)
            if (eng_out_vld[k] && !overflow[k])
                hold_data[k] <= eng_out[k*OUT_W +: OUT_W];
    end

endmodule
